// File: rtl/periph_reg_arbiter.sv
// periph_reg_arbiter: round-robin arbiter that locks one of NUM_REQ register-bus
// requesters onto a shared peripheral bus for the duration of one transfer.
// Two-state FSM (IDLE/BUSY); arbitration takes one IDLE cycle, the transfer
// completes on the first BUSY cycle with slv_rsp_i.ready high.
// Optional feature: define PERIPH_ARB_TIMEOUT_EN to abort a transfer with an
// error response once the wait counter reaches TIMEOUT_CYCLES without ready.

package reg_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module periph_reg_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter type         req_t          = reg_pkg::reg_req_t,
  parameter type         rsp_t          = reg_pkg::reg_rsp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  req_t                       req_i [NUM_REQ],
  output rsp_t                       rsp_o [NUM_REQ],
  output req_t                       slv_req_o,
  input  rsp_t                       slv_rsp_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic                       timeout_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] next_ptr;
  logic             any_valid;
  logic             busy;
  logic             gnt_valid;
  logic             abort;
  rsp_t             abort_rsp;

  assign busy      = (state_q == BUSY);
  assign gnt_valid = busy && req_i[grant_q].valid;
  assign next_ptr  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin : rr_pick
    int unsigned idx;
    idx       = 0;
    winner    = rr_ptr_q;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!any_valid && req_i[idx].valid) begin
        any_valid = 1'b1;
        winner    = IDX_W'(idx);
      end
    end
  end

`ifdef PERIPH_ARB_TIMEOUT_EN
  logic [15:0] wait_q;

  // Wait counter: zero whenever IDLE, counts BUSY cycles that lack ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
    end else if (!busy) begin
      wait_q <= '0;
    end else if (!slv_rsp_i.ready) begin
      wait_q <= wait_q + 16'd1;
    end
  end

  // Ready has priority: an abort only fires when ready is low.
  assign abort = gnt_valid && !slv_rsp_i.ready && (wait_q == 16'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign abort              = 1'b0;
`endif

  // Error response substituted for the slave response on an abort cycle.
  always_comb begin
    abort_rsp       = '0;
    abort_rsp.error = 1'b1;
    abort_rsp.ready = 1'b1;
  end

  // Next-state logic: a dropped valid aborts silently without moving rr_ptr.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    if (state_q == IDLE) begin
      if (any_valid) begin
        state_d = BUSY;
        grant_d = winner;
      end
    end else begin
      if (!req_i[grant_q].valid) begin
        state_d = IDLE;
      end else if (slv_rsp_i.ready || abort) begin
        state_d  = IDLE;
        rr_ptr_d = next_ptr;
      end
    end
  end

  // State, round-robin pointer and locked grant registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  // Forward the granted request; all-zero when not valid or on abort.
  always_comb begin
    slv_req_o = '0;
    if (gnt_valid && !abort) begin
      slv_req_o = req_i[grant_q];
    end
  end

  // Route the response to the granted requester only; others stay zero.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rsp_o[k] = '0;
      if (gnt_valid && (grant_q == IDX_W'(k))) begin
        rsp_o[k] = abort ? abort_rsp : slv_rsp_i;
      end
    end
  end

  assign busy_o      = busy;
  assign grant_idx_o = grant_q;
  assign timeout_o   = abort;

endmodule

// File: doc/periph_reg_arbiter.md
PERIPH_REG_ARBITER -- requirements
Module: periph_reg_arbiter

Interface
REQ-001: Parameter NUM_REQ, default 2, SHALL set the number of register-bus requesters (legal range 2..4).
REQ-002: Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum BUSY cycles before a timeout abort (legal range 1..65535).
REQ-003: Parameters req_t and rsp_t SHALL be the reg_pkg request and response types: addr, write, wdata, wstrb, valid / rdata, error, ready.
REQ-004: clk_i  input  1  sole clock.
REQ-005: rst_ni  input  1  asynchronous active-low reset.
REQ-006: req_i  input  req_t[NUM_REQ]  requester requests.
REQ-007: rsp_o  output  rsp_t[NUM_REQ]  requester responses.
REQ-008: slv_req_o  output  req_t  request to the shared peripheral bus.
REQ-009: slv_rsp_i  input  rsp_t  response from the shared peripheral bus.
REQ-010: busy_o  output  1  high while in BUSY.
REQ-011: grant_idx_o  output  $clog2(NUM_REQ)  locked requester index.
REQ-012: timeout_o  output  1  one-cycle pulse on a timeout abort.

Function
REQ-013: The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-014: In IDLE with any req_i[k].valid high, the next state SHALL be BUSY, with grant_idx registered to the round-robin winner.
REQ-015: The winner SHALL be the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-016: Arbitration latency SHALL be exactly one cycle; slv_req_o.valid SHALL never be high in IDLE.
REQ-017: In BUSY, slv_req_o SHALL equal req_i[grant_idx] combinationally.
REQ-018: In BUSY, rsp_o[grant_idx] SHALL equal slv_rsp_i combinationally.
REQ-019: Non-granted rsp_o entries SHALL be all-zero at all times; in IDLE every rsp_o entry is all-zero.
REQ-020: In BUSY, a cycle with slv_rsp_i.ready high SHALL complete the transfer: next state IDLE, rr_ptr <= (grant_idx+1) mod NUM_REQ.
REQ-021: The request and completion cycle SHALL be decided by valid only; back-to-back transfers therefore take 2 cycles minimum per transfer (IDLE then BUSY).
REQ-022: If req_i[grant_idx].valid drops in BUSY before ready (protocol violation), the block SHALL return to IDLE next cycle with no response and rr_ptr unchanged.
REQ-023: A 16-bit wait counter SHALL be cleared on IDLE->BUSY and SHALL increment each BUSY cycle without ready.
REQ-024: A new request arriving while BUSY SHALL wait; grant_idx SHALL never change in BUSY.
REQ-025: slv_req_o fields SHALL be zero whenever slv_req_o.valid is low.

Reset
REQ-026: While rst_ni is low, the block SHALL hold state=IDLE, rr_ptr=0, grant_idx=0, wait counter=0, busy_o=0, timeout_o=0, slv_req_o all-zero and rsp_o all-zero.
REQ-027: Reset asserted mid-transfer SHALL abort the transfer immediately, with no response issued.
REQ-028: The first arbitration after reset SHALL favour requester 0.

Configuration
REQ-029: Macro PERIPH_ARB_TIMEOUT_EN SHALL, when defined, enable timeout abort on the cycle the wait counter equals TIMEOUT_CYCLES with ready low.
REQ-030: On that abort cycle the block SHALL drive slv_req_o.valid=0 and rsp_o[grant_idx]={rdata=0, error=1, ready=1}.
REQ-031: On that abort cycle the block SHALL pulse timeout_o, go to IDLE next cycle and advance rr_ptr as on completion.
REQ-032: If ready and timeout coincide, ready SHALL win: normal completion, no timeout_o pulse.
REQ-033: Without PERIPH_ARB_TIMEOUT_EN, the counter and timeout logic SHALL be absent, timeout_o SHALL be tied 0, and BUSY SHALL wait indefinitely.

Verification
REQ-034: Single request: req 0 read, addr 0x20000010; slave ready on 2nd BUSY cycle with rdata 0xA5A5A5A5 -> rsp_o[0] returns 0xA5A5A5A5 with ready=1, error=0; busy_o high for 2 cycles.
REQ-035: Contention: req 0 and req 1 both valid after reset, slave ready immediately -> grant order 0,1,0,1; each transfer takes 2 cycles; non-granted rsp stays zero.
REQ-036: Fairness: req 1 continuously valid, req 0 pulses once -> req 0 served within one transfer of its assertion.
REQ-037: Timeout (macro on, TIMEOUT_CYCLES=4): slave never ready -> after 4 BUSY cycles rsp error=1, ready=1, rdata=0; timeout_o pulses once; next requester granted.
REQ-038: Coincidence (macro on): slave ready on the exact timeout cycle -> normal data returned, timeout_o stays 0.
REQ-039: Reset mid-BUSY: rst_ni low for 1 cycle during BUSY -> all outputs zero, rr_ptr=0, no response pulse.
